vexec_unit: RTL

- Parametrised multi-cycle vector execution engine. It is the successor to the fixed 5-lane single-cycle vector register file and VALU pair in the core datapath.
- Holds NUM_VREGS vector registers of MAX_VL elements each. Executes one element-wise op over vl elements, LANES elements per cycle.
- Uses a start/ready/done handshake with the scalar control path.
- A host port loads and inspects elements while the unit is idle.

---
 rtl/vexec_if.sv | 49 ++++
 rtl/vexec_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vexec_if.sv
// vexec_if: control handshake and host element port of the vector execution unit.
// The master modport is the scalar control path / host, the slave modport is the unit.
`timescale 1ns/1ps

interface vexec_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_VREGS = 16,
    parameter int MAX_VL    = 16
);
    localparam int RW = (NUM_VREGS > 1) ? $clog2(NUM_VREGS) : 1;
    localparam int IW = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;
    localparam int LW = $clog2(MAX_VL + 1);

    // operation request
    logic              start;
    logic [2:0]        op;
    logic [RW-1:0]     vd;
    logic [RW-1:0]     va;
    logic [RW-1:0]     vb;
    logic [LW-1:0]     vl;
    logic [DATA_W-1:0] scalar;

    // status
    logic              ready;
    logic              busy;
    logic              done;
    logic [3:0]        flags;

    // host element access
    logic              wr_en;
    logic [RW-1:0]     wr_reg;
    logic [IW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [RW-1:0]     rd_reg;
    logic [IW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output start, op, vd, va, vb, vl, scalar,
        output wr_en, wr_reg, wr_idx, wr_data, rd_reg, rd_idx,
        input  ready, busy, done, flags, rd_data
    );

    modport slave (
        input  start, op, vd, va, vb, vl, scalar,
        input  wr_en, wr_reg, wr_idx, wr_data, rd_reg, rd_idx,
        output ready, busy, done, flags, rd_data
    );
endinterface

// File: rtl/vexec_unit.sv
// vexec_unit: multi-cycle element-wise vector engine over NUM_VREGS registers of
// MAX_VL elements, LANES elements per EXEC beat, with NZCV flags of the last op.
// Optional build macro VEXEC_SAT_EN: ADD/SUB/ADDS saturate to the signed range.
`timescale 1ns/1ps

module vexec_unit #(
    parameter int DATA_W    = 32,
    parameter int LANES     = 4,
    parameter int NUM_VREGS = 16,
    parameter int MAX_VL    = 16
) (
    input logic    clk,
    input logic    reset,
    vexec_if.slave bus
);
    localparam int RW = (NUM_VREGS > 1) ? $clog2(NUM_VREGS) : 1;
    localparam int IW = (MAX_VL > 1) ? $clog2(MAX_VL) : 1;
    localparam int LW = $clog2(MAX_VL + 1);
    localparam int M  = DATA_W - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_ADDS = 3'b101;
    localparam logic [2:0] OP_EOR  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Per-element ALU; returns {carry, overflow, result}. Carry comes from the
    // unsaturated sum; logic ops and MOV leave carry and overflow clear.
    function automatic logic [DATA_W+1:0] lane_alu(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] s
    );
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] res;
        logic              ovf;
        sum = {(DATA_W+1){1'b0}};
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                ovf = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                // a + ~b + 1: carry out set means no borrow
                sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                ovf = (a[M] != b[M]) && (sum[M] != a[M]);
            end
            OP_ADDS: begin
                sum = {1'b0, a} + {1'b0, s};
                ovf = (a[M] == s[M]) && (sum[M] != a[M]);
            end
            OP_AND:  sum = {1'b0, a & b};
            OP_ORR:  sum = {1'b0, a | b};
            OP_MOV:  sum = {1'b0, b};
            OP_EOR:  sum = {1'b0, a ^ b};
            default: sum = {(DATA_W+1){1'b0}};
        endcase
        res = sum[DATA_W-1:0];
`ifdef VEXEC_SAT_EN
        // overflow direction is given by the sign of the first operand
        if (ovf) begin
            res = a[M] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            res = sum[DATA_W-1:0];
        end
`endif
        return {sum[DATA_W], ovf, res};
    endfunction

    // vector register file (deliberately not reset)
    logic [DATA_W-1:0] r_vregs [NUM_VREGS][MAX_VL];

    state_t            r_state;
    logic [2:0]        r_op;
    logic [RW-1:0]     r_vd;
    logic [RW-1:0]     r_va;
    logic [RW-1:0]     r_vb;
    logic [DATA_W-1:0] r_scalar;
    logic [LW-1:0]     r_evl;
    logic [LW-1:0]     r_beat;
    logic [LW-1:0]     r_last_beat;
    logic              r_acc_n;
    logic              r_acc_z;
    logic              r_acc_c;
    logic              r_acc_v;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_flags;

    logic [LW-1:0]     w_evl;
    logic [LW-1:0]     w_last_beat;
    int                w_beats;
    logic              w_lane_en  [LANES];
    logic [IW-1:0]     w_lane_idx [LANES];
    logic [DATA_W-1:0] w_lane_res [LANES];
    logic              w_lane_c   [LANES];
    logic              w_lane_v   [LANES];
    logic              w_flag_n;
    logic              w_flag_z;
    logic              w_flag_c;
    logic              w_flag_v;
    logic              w_host_we;

    // Effective length clamp and index of the final beat for the requested op.
    always_comb begin
        if (bus.vl > LW'(MAX_VL)) begin
            w_evl = LW'(MAX_VL);
        end else begin
            w_evl = bus.vl;
        end
        w_beats = (int'(w_evl) + LANES - 1) / LANES;
        if (w_beats > 0) begin
            w_last_beat = LW'(w_beats - 1);
        end else begin
            w_last_beat = {LW{1'b0}};
        end
    end

    // Lane datapath for the current beat plus running flag accumulation.
    always_comb begin : lane_comb
        logic [DATA_W+1:0] w_alu;
        int                w_idx;
        w_flag_n = r_acc_n;
        w_flag_z = r_acc_z;
        w_flag_c = r_acc_c;
        w_flag_v = r_acc_v;
        for (int l = 0; l < LANES; l++) begin
            w_idx         = int'(r_beat) * LANES + l;
            w_lane_en[l]  = (r_state == S_EXEC) && (w_idx < int'(r_evl)) && (r_op != OP_RSV);
            w_lane_idx[l] = IW'(w_idx);
            w_alu         = lane_alu(r_op, r_vregs[r_va][w_lane_idx[l]],
                                     r_vregs[r_vb][w_lane_idx[l]], r_scalar);
            w_lane_c[l]   = w_alu[DATA_W+1];
            w_lane_v[l]   = w_alu[DATA_W];
            w_lane_res[l] = w_alu[DATA_W-1:0];
            if (w_lane_en[l]) begin
                // lanes run in ascending index, so the last enabled one on the
                // final beat is element evl-1
                w_flag_n = w_lane_res[l][M];
                w_flag_z = w_flag_z && (w_lane_res[l] == {DATA_W{1'b0}});
                w_flag_c = w_flag_c || w_lane_c[l];
                w_flag_v = w_flag_v || w_lane_v[l];
            end else begin
                w_flag_n = w_flag_n;
            end
        end
    end

    assign w_host_we = bus.wr_en && (r_state == S_IDLE);

    // Register file writes: host port in IDLE, lane results in EXEC (never both).
    always_ff @(posedge clk) begin
        if (w_host_we) begin
            r_vregs[bus.wr_reg][bus.wr_idx] <= bus.wr_data;
        end
        for (int l = 0; l < LANES; l++) begin
            if (w_lane_en[l]) begin
                r_vregs[r_vd][w_lane_idx[l]] <= w_lane_res[l];
            end
        end
    end

    // Control FSM with registered status outputs; reset aborts any op at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op        <= 3'b000;
            r_vd        <= {RW{1'b0}};
            r_va        <= {RW{1'b0}};
            r_vb        <= {RW{1'b0}};
            r_scalar    <= {DATA_W{1'b0}};
            r_evl       <= {LW{1'b0}};
            r_beat      <= {LW{1'b0}};
            r_last_beat <= {LW{1'b0}};
            r_acc_n     <= 1'b0;
            r_acc_z     <= 1'b1;
            r_acc_c     <= 1'b0;
            r_acc_v     <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_flags     <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op        <= bus.op;
                        r_vd        <= bus.vd;
                        r_va        <= bus.va;
                        r_vb        <= bus.vb;
                        r_scalar    <= bus.scalar;
                        r_evl       <= w_evl;
                        r_beat      <= {LW{1'b0}};
                        r_last_beat <= w_last_beat;
                        r_acc_n     <= 1'b0;
                        r_acc_z     <= 1'b1;
                        r_acc_c     <= 1'b0;
                        r_acc_v     <= 1'b0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_evl == {LW{1'b0}}) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_flags <= (bus.op == OP_RSV) ? 4'b0000 : 4'b0100;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_acc_n <= w_flag_n;
                    r_acc_z <= w_flag_z;
                    r_acc_c <= w_flag_c;
                    r_acc_v <= w_flag_v;
                    if (r_beat == r_last_beat) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_flags <= (r_op == OP_RSV) ? 4'b0000
                                                    : {w_flag_n, w_flag_z, w_flag_c, w_flag_v};
                    end else begin
                        r_beat <= r_beat + {{(LW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.flags   = r_flags;
    assign bus.rd_data = r_vregs[bus.rd_reg][bus.rd_idx];

endmodule
